// File: rtl/pid_d_term_seq.sv
// Derivative term of the servo PID loop: backward difference of the error sample times a
// loadable gain Kd, computed with a serial shift-add multiplier, then shifted and saturated.
module pid_d_term_seq #(
    parameter int unsigned W     = 13,
    parameter int unsigned OUT_W = 2 * W,
    parameter int unsigned FRAC  = 0
) (
    input  logic                    Clk_G,
    input  logic                    Rst_G,
    input  logic signed [W-1:0]     Pot,
    input  logic                    Rx_En,
    input  logic signed [W-1:0]     Kd_In,
    input  logic                    Kd_Ld,
    output logic signed [OUT_W-1:0] R_Mul_D,
    output logic                    Done,
    output logic                    Busy,
    output logic                    Sat,
    output logic                    Ovr_Run
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned CW = $clog2(W + 1);
    localparam logic signed [PW-1:0] SAT_MAX = PW'({(OUT_W - 1){1'b1}});
    localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, DIFF, MUL, SAT} state_t;

    state_t state, state_next;

    logic signed [W-1:0] e_cur, e_prev, kd_reg;
    logic                prev_valid;
    logic [CW-1:0]       cnt;
    logic [W-1:0]        mplier;
    logic [PW-1:0]       mcand, acc;
    logic                neg;

    logic signed [W:0]    diff_c;
    logic [W-1:0]         diff_mag_c, kd_mag_c;
    logic signed [PW-1:0] prod_c, shifted_c, clamped_c;
    logic                 sat_c;

    // State register
    always_ff @(posedge Clk_G or negedge Rst_G) begin
        if (!Rst_G) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic: DIFF and SAT take one cycle, MUL one cycle per multiplier bit
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Rx_En) state_next = DIFF;
            DIFF:    state_next = MUL;
            MUL:     if (cnt == CW'(W - 1)) state_next = SAT;
            SAT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand preparation: sign-magnitude split of the difference and the gain
    always_comb begin
        diff_c     = '0;
        if (prev_valid) diff_c = {e_cur[W-1], e_cur} - {e_prev[W-1], e_prev};
        diff_mag_c = diff_c[W] ? W'(-diff_c) : W'(diff_c);
        kd_mag_c   = kd_reg[W-1] ? W'(-kd_reg) : W'(kd_reg);
    end

    // Result shaping: restore sign, arithmetic shift (floor), clamp to the output range
    always_comb begin
        prod_c    = neg ? PW'(-acc) : acc;
        shifted_c = prod_c >>> FRAC;
        clamped_c = shifted_c;
        sat_c     = 1'b0;
        if (shifted_c > SAT_MAX) begin
            clamped_c = SAT_MAX;
            sat_c     = 1'b1;
        end else if (shifted_c < SAT_MIN) begin
            clamped_c = SAT_MIN;
            sat_c     = 1'b1;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge Clk_G or negedge Rst_G) begin
        if (!Rst_G) begin
            e_cur      <= '0;
            e_prev     <= '0;
            prev_valid <= 1'b0;
            kd_reg     <= '0;
            cnt        <= '0;
            mplier     <= '0;
            mcand      <= '0;
            acc        <= '0;
            neg        <= 1'b0;
            R_Mul_D    <= '0;
            Done       <= 1'b0;
            Busy       <= 1'b0;
            Sat        <= 1'b0;
            Ovr_Run    <= 1'b0;
        end else begin
            if (Kd_Ld) kd_reg <= Kd_In;
            if (Rx_En && state != IDLE) Ovr_Run <= 1'b1;
            Done <= (state == SAT);
            Busy <= (state_next != IDLE) || (state == SAT);
            case (state)
                IDLE: if (Rx_En) e_cur <= Pot;
                DIFF: begin
                    e_prev     <= e_cur;
                    prev_valid <= 1'b1;
                    mcand      <= PW'(diff_mag_c);
                    mplier     <= kd_mag_c;
                    neg        <= diff_c[W] ^ kd_reg[W-1];
                    acc        <= '0;
                    cnt        <= '0;
                end
                MUL: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
                SAT: begin
                    R_Mul_D <= OUT_W'(clamped_c);
                    Sat     <= sat_c;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pid_d_term_seq.sv
// Scoreboard bench for pid_d_term_seq: three instances (default, OUT_W=20, FRAC=4) share
// stimulus; expected results are queued at issue and checked whenever Done appears.
module tb_pid_d_term_seq;

    localparam int unsigned W = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n, rx_en, kd_ld;
    logic signed [W-1:0] pot, kd_in;

    logic signed [25:0] r_m, r_f;
    logic signed [19:0] r_s;
    logic d_m, b_m, s_m, o_m;
    logic d_s, b_s, s_s, o_s;
    logic d_f, b_f, s_f, o_f;

    pid_d_term_seq #(.W(W)) u_main (
        .Clk_G(clk), .Rst_G(rst_n), .Pot(pot), .Rx_En(rx_en), .Kd_In(kd_in), .Kd_Ld(kd_ld),
        .R_Mul_D(r_m), .Done(d_m), .Busy(b_m), .Sat(s_m), .Ovr_Run(o_m));

    pid_d_term_seq #(.W(W), .OUT_W(20)) u_s20 (
        .Clk_G(clk), .Rst_G(rst_n), .Pot(pot), .Rx_En(rx_en), .Kd_In(kd_in), .Kd_Ld(kd_ld),
        .R_Mul_D(r_s), .Done(d_s), .Busy(b_s), .Sat(s_s), .Ovr_Run(o_s));

    pid_d_term_seq #(.W(W), .FRAC(4)) u_f4 (
        .Clk_G(clk), .Rst_G(rst_n), .Pot(pot), .Rx_En(rx_en), .Kd_In(kd_in), .Kd_Ld(kd_ld),
        .R_Mul_D(r_f), .Done(d_f), .Busy(b_f), .Sat(s_f), .Ovr_Run(o_f));

    typedef struct {
        longint m; longint ms;
        longint s; longint ss;
        longint f; longint fs;
        int     at;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every Done pops one expected result
    always @(negedge clk) begin
        if (rst_n && (d_m || d_s || d_f)) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = q.pop_front();
                chk("done_sync", {d_m, d_s, d_f}, 3'b111);
                chk("latency", cyc, mon_e.at);
                chk("main_result", r_m, mon_e.m);
                chk("main_sat", s_m, mon_e.ms);
                chk("s20_result", r_s, mon_e.s);
                chk("s20_sat", s_s, mon_e.ss);
                chk("f4_result", r_f, mon_e.f);
                chk("f4_sat", s_f, mon_e.fs);
            end
        end
    end

    task automatic load_kd(input logic signed [W-1:0] k);
        kd_in = k;
        kd_ld = 1'b1;
        @(negedge clk);
        kd_ld = 1'b0;
    endtask

    task automatic issue(input logic signed [W-1:0] p, input longint m, input longint ms,
                         input longint s, input longint ss, input longint f, input longint fs);
        exp_t e;
        e.m = m; e.ms = ms; e.s = s; e.ss = ss; e.f = f; e.fs = fs;
        e.at = cyc + 16;
        q.push_back(e);
        pot   = p;
        rx_en = 1'b1;
        @(negedge clk);
        rx_en = 1'b0;
        kd_ld = 1'b0;
        chk("busy_after_accept", b_m, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!d_m && n < 40);
        if (!d_m) chk("done_timeout", 0, 1);
        chk("busy_in_done_cycle", b_m, 1);
    endtask

    task automatic run(input logic signed [W-1:0] p, input longint m, input longint ms,
                       input longint s, input longint ss, input longint f, input longint fs);
        issue(p, m, ms, s, ss, f, fs);
        wait_done();
        @(negedge clk);
        chk("busy_low_idle", b_m, 0);
    endtask

    initial begin
        rst_n = 1'b0; pot = '0; rx_en = 1'b0; kd_in = '0; kd_ld = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_result", r_m, 0);
        chk("rst_done", d_m, 0);
        chk("rst_busy", b_m, 0);
        chk("rst_sat", s_m, 0);
        chk("rst_ovr", o_m, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // First sample yields zero, then normal conversions
        load_kd(3);
        run(100, 0, 0, 0, 0, 0, 0);
        run(150, 150, 0, 150, 0, 9, 0);
        load_kd(7);
        run(145, -35, 0, -35, 0, -3, 0);
        run(4095, 27650, 0, 27650, 0, 1728, 0);

        // Extreme operands, saturation on the 20-bit instance
        load_kd(-4096);
        run(-4096, 33550336, 0, 524287, 1, 2096896, 0);
        run(4095, -33550336, 0, -524288, 1, -2096896, 0);
        chk("ovr_clear", o_m, 0);

        // Overrun mid-conversion, then accept in the Done cycle
        load_kd(3);
        issue(4000, -285, 0, -285, 0, -18, 0);
        repeat (4) @(negedge clk);
        pot   = -1000;
        rx_en = 1'b1;
        @(negedge clk);
        rx_en = 1'b0;
        wait_done();
        chk("ovr_set", o_m, 1);
        issue(4010, 30, 0, 30, 0, 1, 0);
        wait_done();
        @(negedge clk);

        // Gain load mid-MUL affects only the next conversion
        issue(4020, 30, 0, 30, 0, 1, 0);
        repeat (6) @(negedge clk);
        load_kd(7);
        wait_done();
        @(negedge clk);
        run(4030, 70, 0, 70, 0, 4, 0);

        // Gain load on the accepting edge is used immediately
        kd_in = -2;
        kd_ld = 1'b1;
        issue(4050, -40, 0, -40, 0, -3, 0);
        wait_done();
        @(negedge clk);
        chk("ovr_sticky", o_m, 1);

        // Reset mid-MUL discards the conversion
        pot   = 100;
        rx_en = 1'b1;
        @(negedge clk);
        rx_en = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_result", r_m, 0);
        chk("midrst_f4_result", r_f, 0);
        chk("midrst_busy", b_m, 0);
        chk("midrst_done", d_m, 0);
        chk("midrst_ovr", o_m, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        load_kd(5);
        run(50, 0, 0, 0, 0, 0, 0);
        run(60, 50, 0, 50, 0, 3, 0);

        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pid_d_term_seq.md
# pid_d_term_seq

Parametrised, sequential derivative-term unit for the servo PID loop. On each `Rx_En` strobe it captures a signed error sample, forms the backward difference against the previous sample, and multiplies that difference by a runtime-loadable gain `Kd`. It uses a shift-add multiplier, then shifts and saturates the product to the output width. It sits between the error/ADC front end and the PID summation stage, and succeeds the fixed 13-bit derivative block with these additions: configurable widths, loadable gain, a done/busy handshake, saturation and overrun detection.

## Interface
- `W`, 13: width of error sample and of `Kd` (signed).
- `OUT_W`, 2*W: width of `R_Mul_D` (signed). Must satisfy W+1 ≤ OUT_W ≤ 2*W.
- `FRAC`, 0: arithmetic right shift applied to the product before saturation. Range 0..W.
- `Clk_G` in, 1: single system clock, rising edge.
- `Rst_G` in, 1: asynchronous, active-low reset.
- `Pot` in, W: signed error sample, sampled when `Rx_En` is accepted.
- `Rx_En` in, 1: one-cycle sample strobe.
- `Kd_In` in, W: signed gain value.
- `Kd_Ld` in, 1: loads `Kd_In` into the gain register.
- `R_Mul_D` out, OUT_W: signed result; holds its value between completions.
- `Done` out, 1: one-cycle pulse, asserted in the same cycle `R_Mul_D` updates.
- `Busy` out, 1: high from the cycle after acceptance until `Done`, inclusive.
- `Sat` out, 1: saturation flag for the current `R_Mul_D`; updates together with it.
- `Ovr_Run` out, 1: sticky flag, set when `Rx_En` arrives while `Busy`.

## Operation
- The FSM has four states: IDLE, DIFF, MUL, SAT.
- IDLE to DIFF when `Rx_En`=1. The accepting edge latches `Pot` into `e_cur`.
- DIFF (1 cycle):
  - diff = e_cur − e_prev, width W+1. Overflow is impossible.
  - If `prev_valid`=0, diff is forced to 0.
  - e_prev ← e_cur; `prev_valid` ← 1.
  - The Kd operand is latched from the gain register.
  - The magnitudes of diff (W bits) and Kd (W bits; −2^(W−1) maps to 2^(W−1)) are loaded, and sign = sign(diff) XOR sign(Kd).
- MUL (exactly W cycles): unsigned shift-add, one multiplier bit per cycle, into a 2W-bit accumulator.
- SAT (1 cycle):
  - The signed product is formed (negated if sign=1; zero is never negative).
  - It is arithmetically shifted right by FRAC, which rounds toward −∞.
  - The result is clamped to [−2^(OUT_W−1), 2^(OUT_W−1)−1]. `Sat`=1 if clamping occurred.
  - `R_Mul_D` and `Sat` register the result, `Done` pulses, and the FSM returns to IDLE.
- Gain register:
  - Writable in any state via `Kd_Ld`.
  - A write during DIFF, MUL or SAT affects only the next conversion.
  - If `Kd_Ld` and an accepted `Rx_En` fall on the same edge, the new `Kd_In` is used.
- `Rx_En` while not IDLE: ignored, with no effect on the running conversion. `Ovr_Run` ← 1, cleared only by reset.
- `Rx_En` is accepted in the IDLE cycle that immediately follows `Done`.

## Timing
- With `Rx_En` sampled at edge k, `R_Mul_D`/`Sat`/`Done` update at edge k+W+3 (16 for W=13).
- `Busy` is high during edges k+1..k+W+3.
- Maximum throughput is one sample per W+3 cycles.
- `Done` is high for exactly one cycle.
- Reset (asynchronous, any state, including mid-MUL):
  - FSM → IDLE.
  - `R_Mul_D`=0, `Done`=0, `Busy`=0, `Sat`=0, `Ovr_Run`=0.
  - e_prev=0, `prev_valid`=0, Kd register=0, accumulator cleared.
  - Any in-flight result is discarded. The first conversion after reset outputs 0.
- Release of `Rst_G` is synchronised externally. The block must not accept `Rx_En` in the release cycle unless it is high at the first active edge.

## Test plan
- **First sample and normal conversion.** Reset, then `Kd_Ld` with Kd=3, then `Rx_En` with Pot=100 → after 16 cycles `Done`=1, `R_Mul_D`=0. Next `Rx_En` with Pot=150 → `R_Mul_D`=150, `Sat`=0.
- **Extreme operands.** Pot=4095, then Pot=−4096 with Kd=−4096 (W=13, defaults) → diff=−8191, `R_Mul_D`=33,550,336, `Sat`=0. Reversed order (−4096 then 4095) → −33,550,336.
- **Saturation and shift.**
  - OUT_W=20, FRAC=0, same extremes → `R_Mul_D`=524,287, `Sat`=1. Opposite sign → −524,288, `Sat`=1.
  - FRAC=4 with product −35 → −3.
- **Overrun.** `Rx_En` at cycle 5 of a conversion with a different Pot → the result is unaffected, `Ovr_Run`=1 until reset. `Rx_En` the cycle after `Done` → accepted.
- **Gain timing.** `Kd_Ld` (Kd=7) mid-MUL → the current result uses the old Kd and the next one uses 7. `Kd_Ld` together with `Rx_En` → the new Kd is used.
- **Reset mid-operation.** Assert `Rst_G` low during MUL → all outputs 0 immediately, with no `Done`. The next conversion returns 0 because `prev_valid` was cleared.
